ucie_ctl_rx: RTL and testbench

Receive-direction datapath of the UCIe controller, sitting between the RDI (physical-layer side) and the FDI (protocol-layer side). Words arriving on RDI are accepted unconditionally, because RDI RX has no backpressure. They are buffered in an internal single-clock FIFO and presented to the protocol layer with a valid/ready handshake. A small FSM gates all traffic on the FDI link state, flushes the buffer on leaving Active, and flags overflow.

---
 rtl/ucie_ctl_rx.sv | 72 +++++++
 tb/tb_ucie_ctl_rx.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ucie_ctl_rx.sv
// ucie_ctl_rx: RDI-to-FDI receive path with a show-ahead FIFO gated by the FDI link state.
// Leaving Active flushes the buffer and clears the sticky overflow flag.
module ucie_ctl_rx #(
    parameter int UCIE_ACTIVE   = 1,
    parameter int DATA_WIDTH_RX = 64,
    parameter int FIFO_DEPTH_RX = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [3:0]                       i_fdi_pl_state_sts,
    input  logic                             i_rdi_pl_valid,
    input  logic [DATA_WIDTH_RX-1:0]         i_rdi_pl_data,
    input  logic                             i_fdi_lp_rx_rdy,
    output logic                             o_fdi_pl_valid,
    output logic [DATA_WIDTH_RX-1:0]         o_fdi_pl_data,
    output logic                             o_rx_overf_err,
    output logic [$clog2(FIFO_DEPTH_RX):0]   o_rx_level
);
    localparam int AW = $clog2(FIFO_DEPTH_RX);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH_RX);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    state_t state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
    logic err_q, err_d;
    logic act, en, full, empty, push, pop, wr, leave;
    logic [DATA_WIDTH_RX-1:0] mem [FIFO_DEPTH_RX];

    always_comb begin
        act      = i_fdi_pl_state_sts == 4'(UCIE_ACTIVE);
        en       = state_q == ACTIVE && act;
        leave    = state_q == ACTIVE && !act;
        full     = level_q == FULL_LVL;
        empty    = level_q == '0;
        push     = en && i_rdi_pl_valid;
        pop      = en && !empty && i_fdi_lp_rx_rdy;
        // a pop on a full buffer frees the slot this push lands in
        wr       = push && (!full || pop);
        state_d  = state_q == IDLE   ? (act ? ACTIVE : IDLE) :
                   state_q == ACTIVE ? (act ? ACTIVE : FLUSH) : IDLE;
        wr_ptr_d = leave ? '0 : wr_ptr_q + (AW+1)'(wr);
        rd_ptr_d = leave ? '0 : rd_ptr_q + (AW+1)'(pop);
        level_d  = leave ? '0 : level_q + (AW+1)'(wr) - (AW+1)'(pop);
        err_d    = leave ? 1'b0 : err_q || (push && full && !pop);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr) mem[wr_ptr_q[AW-1:0]] <= i_rdi_pl_data;
    end

    assign o_fdi_pl_valid = en && !empty;
    assign o_fdi_pl_data  = mem[rd_ptr_q[AW-1:0]];
    assign o_rx_overf_err = err_q;
    assign o_rx_level     = level_q;
endmodule

// File: tb/tb_ucie_ctl_rx.sv
// tb_ucie_ctl_rx: scoreboard bench for ucie_ctl_rx with directed phases and a random phase.
// A queue-based link/buffer model predicts accepted words; a negedge monitor compares the DUT against it.
module tb_ucie_ctl_rx;
    localparam int DW = 64;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    sts = 4'd0;
    logic          rvalid = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          rdy = 1'b0;
    logic          ovalid;
    logic [DW-1:0] odata;
    logic          oerr;
    logic [3:0]    olevel;

    ucie_ctl_rx #(.UCIE_ACTIVE(1), .DATA_WIDTH_RX(DW), .FIFO_DEPTH_RX(D)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_fdi_pl_state_sts(sts),
        .i_rdi_pl_valid(rvalid), .i_rdi_pl_data(rdata), .i_fdi_lp_rx_rdy(rdy),
        .o_fdi_pl_valid(ovalid), .o_fdi_pl_data(odata),
        .o_rx_overf_err(oerr), .o_rx_level(olevel)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // model: link phase 0=down/idle, 1=active, 2=quiet after leaving active
    int          m_phase = 0;
    logic [DW-1:0] sb[$];
    int          m_level = 0;
    bit          m_err = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            sb.delete();
            m_level = 0;
            m_err = 0;
        end else begin
            if (m_phase == 1 && sts == 4'd1 && rvalid) begin
                if (sb.size() < D) sb.push_back(rdata);
                else m_err = 1;
            end
            if (m_phase == 1 && sts != 4'd1) begin
                sb.delete();
                m_err = 0;
            end
            m_phase = (m_phase == 0) ? (sts == 4'd1 ? 1 : 0) :
                      (m_phase == 1) ? (sts == 4'd1 ? 1 : 2) : 0;
            m_level = sb.size();
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            bit exp_v;
            exp_v = (m_phase == 1) && (sts == 4'd1) && (sb.size() > 0);
            chk("level", DW'(olevel), DW'(m_level));
            chk("err", DW'(oerr), DW'(m_err));
            chk("valid", DW'(ovalid), DW'(exp_v));
            if (ovalid && sb.size() > 0) begin
                chk("data", odata, sb[0]);
                // consumed on the coming edge; removing it now lets a push into a full buffer land
                if (rdy) void'(sb.pop_front());
            end
        end
    end

    task automatic step(input logic [3:0] s, input logic v, input logic [DW-1:0] d, input logic r);
        sts = s;
        rvalid = v;
        rdata = d;
        rdy = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", DW'(ovalid), 0);
        chk("rst_err", DW'(oerr), 0);
        chk("rst_level", DW'(olevel), 0);
        rst_n = 1'b1;
        // basic transfer
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 1, DW'(8'hA0 + i), 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        // fill and overflow, then drain
        for (int i = 0; i < 9; i++) step(1, 1, DW'(8'h10 + i), 0);
        repeat (3) step(1, 0, 0, 0);
        chk("ovf_err", DW'(oerr), 1);
        chk("ovf_level", DW'(olevel), 8);
        repeat (10) step(1, 0, 0, 1);
        // leave active with 5 buffered and err still set
        for (int i = 0; i < 5; i++) step(1, 1, DW'(8'h30 + i), 0);
        chk("pre_leave_err", DW'(oerr), 1);
        step(0, 1, DW'(8'hEE), 1);
        chk("flush_level", DW'(olevel), 0);
        chk("flush_err", DW'(oerr), 0);
        step(1, 1, DW'(8'hEF), 1);
        step(1, 1, DW'(8'hF0), 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        // full plus simultaneous pop
        for (int i = 0; i < 8; i++) step(1, 1, DW'(8'h20 + i), 0);
        step(1, 1, DW'(8'h55), 1);
        chk("fullpop_level", DW'(olevel), 8);
        chk("fullpop_err", DW'(oerr), 0);
        repeat (10) step(1, 0, 0, 1);
        // link not active
        step(0, 0, 0, 1);
        repeat (10) step(0, 1, DW'($urandom), 1);
        chk("down_level", DW'(olevel), 0);
        // random phase
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 3)) : 4'd1,
                 1'($urandom), {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
        // async reset mid-burst with overflow flagged
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(1, 1, DW'(8'h40 + i), 0);
        chk("pre_rst_err", DW'(oerr), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", DW'(ovalid), 0);
        chk("arst_err", DW'(oerr), 0);
        chk("arst_level", DW'(olevel), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 0, 1);
        step(1, 1, DW'(8'h77), 1);
        chk("post_rst_valid", DW'(ovalid), 0);
        step(1, 1, DW'(8'h78), 1);
        repeat (4) step(1, 0, 0, 1);
        chk("drained", DW'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
